isp_debayer_ctrl: RTL and testbench

//  Frame sequencer/configurator for the debayer stage. Tracks in_vsync/in_href timing,

---
 rtl/isp_debayer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_isp_debayer_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_debayer_ctrl.sv
// isp_debayer_ctrl
//   Frame sequencer and configurator for the debayer stage. It follows the
//   in_vsync/in_href sensor timing, counts pixels and lines, and checks each
//   frame against WIDTH x HEIGHT. It also keeps the Bayer phase and enable in
//   shadow registers, which are applied only at frame boundaries.
//
//   Optional feature macro: ISP_DEBAYER_CTRL_STATS_EN. When it is defined the
//   block also has frame_cnt, meas_width and meas_height.
//
// Ports
//   pclk, rst           pixel clock; synchronous active-high reset
//   in_vsync, in_href   sensor frame sync and line valid
//   cfg_bayer/enable    requested CFA phase and enable
//   cfg_update          pulse that captures cfg_* into the pending shadow
//   err_clr             clears the sticky error flags
//   act_bayer/enable    active configuration driven to the debayer
//   frame_start/done    1-cycle frame boundary pulses
//   pix_cnt, line_cnt   current pixel count and completed-line count
//   err_width/height    sticky geometry error flags
//
// state   | meaning
// S_IDLE  | unsynchronised after reset; href ignored, pending cfg applied
// S_VSYNC | vsync high; waiting for it to fall
// S_WAIT  | inside a frame, between lines
// S_LINE  | inside a frame, href high, counting pixels
module isp_debayer_ctrl #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter int BAYER  = 0,
  parameter int CNT_W  = 12
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             in_vsync,
  input  logic             in_href,
  input  logic [1:0]       cfg_bayer,
  input  logic             cfg_enable,
  input  logic             cfg_update,
  input  logic             err_clr,
  output logic [1:0]       act_bayer,
  output logic             act_enable,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic             err_width,
  output logic             err_height
`ifdef ISP_DEBAYER_CTRL_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_height
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_WAIT, S_LINE} state_t;

  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] HEIGHT_C = CNT_W'(HEIGHT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state;
  logic       vsync_d, href_d;
  logic [1:0] pend_bayer;
  logic       pend_enable, pend_vld;

  logic             vs_rise, vs_fall, hr_rise;
  logic             line_end, frame_end, cfg_apply;
  logic             new_err_w, new_err_h;
  logic [CNT_W-1:0] pix_inc, line_len, lines_done;

  always_comb begin
    vs_rise    = in_vsync & ~vsync_d;
    vs_fall    = ~in_vsync & vsync_d;
    hr_rise    = in_href & ~href_d;
    pix_inc    = (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + CNT_W'(1);
    // A line in progress ends on href low, or is cut short by a vsync rise;
    // in the truncated case the current href-high cycle still counts.
    line_end   = (state == S_LINE) && (!in_href || vs_rise);
    line_len   = in_href ? pix_inc : pix_cnt;
    lines_done = line_cnt;
    if (state == S_LINE)
      lines_done = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + CNT_W'(1);
    frame_end  = vs_rise && ((state == S_WAIT) || (state == S_LINE));
    cfg_apply  = frame_end || (state == S_IDLE);
    new_err_w  = line_end && (line_len != WIDTH_C);
    new_err_h  = frame_end && (lines_done != HEIGHT_C);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= S_IDLE;
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      act_bayer   <= 2'(BAYER);
      act_enable  <= 1'b1;
      pend_bayer  <= 2'(BAYER);
      pend_enable <= 1'b1;
      pend_vld    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;
`ifdef ISP_DEBAYER_CTRL_STATS_EN
      frame_cnt   <= '0;
      meas_width  <= '0;
      meas_height <= '0;
`endif
    end else begin
      vsync_d     <= in_vsync;
      href_d      <= in_href;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      // a new error in the same cycle as err_clr keeps the flag set
      err_width   <= (err_width & ~err_clr) | new_err_w;
      err_height  <= (err_height & ~err_clr) | new_err_h;

      if (cfg_update) begin
        pend_bayer  <= cfg_bayer;
        pend_enable <= cfg_enable;
      end
      if (cfg_apply) begin
        // an update arriving on the boundary cycle is applied at that boundary
        if (cfg_update) begin
          act_bayer  <= cfg_bayer;
          act_enable <= cfg_enable;
        end else if (pend_vld) begin
          act_bayer  <= pend_bayer;
          act_enable <= pend_enable;
        end
        pend_vld <= 1'b0;
      end else if (cfg_update) begin
        pend_vld <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (vs_rise) state <= S_VSYNC;
        end
        S_VSYNC: begin
          if (vs_fall) begin
            state    <= S_WAIT;
            line_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (vs_rise) begin
            state      <= S_VSYNC;
            frame_done <= 1'b1;
          end else if (hr_rise) begin
            state       <= S_LINE;
            pix_cnt     <= CNT_W'(1);
            frame_start <= (line_cnt == '0);
          end
        end
        S_LINE: begin
          pix_cnt <= line_len;
          if (line_end) line_cnt <= lines_done;
          if (vs_rise) begin
            state      <= S_VSYNC;
            frame_done <= 1'b1;
          end else if (!in_href) begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase

`ifdef ISP_DEBAYER_CTRL_STATS_EN
      if (line_end) meas_width <= line_len;
      if (frame_end) begin
        frame_cnt   <= frame_cnt + 16'd1;
        meas_height <= lines_done;
      end
`endif
    end
  end

endmodule

// File: tb/tb_isp_debayer_ctrl.sv
module tb_isp_debayer_ctrl;

  localparam int WIDTH  = 16;
  localparam int HEIGHT = 6;
  localparam int BAYER  = 0;
  localparam int CNT_W  = 6;

  logic             pclk = 1'b0;
  logic             rst;
  logic             in_vsync, in_href;
  logic [1:0]       cfg_bayer;
  logic             cfg_enable, cfg_update, err_clr;
  logic [1:0]       act_bayer;
  logic             act_enable, frame_start, frame_done;
  logic [CNT_W-1:0] pix_cnt, line_cnt;
  logic             err_width, err_height;
`ifdef ISP_DEBAYER_CTRL_STATS_EN
  logic [15:0]      frame_cnt;
  logic [CNT_W-1:0] meas_width, meas_height;
`endif

  isp_debayer_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .BAYER(BAYER), .CNT_W(CNT_W)) dut (
    .pclk(pclk), .rst(rst), .in_vsync(in_vsync), .in_href(in_href),
    .cfg_bayer(cfg_bayer), .cfg_enable(cfg_enable), .cfg_update(cfg_update),
    .err_clr(err_clr), .act_bayer(act_bayer), .act_enable(act_enable),
    .frame_start(frame_start), .frame_done(frame_done), .pix_cnt(pix_cnt),
    .line_cnt(line_cnt), .err_width(err_width), .err_height(err_height)
`ifdef ISP_DEBAYER_CTRL_STATS_EN
    , .frame_cnt(frame_cnt), .meas_width(meas_width), .meas_height(meas_height)
`endif
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int   lines;
    logic errh;
  } fd_t;

  fd_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  fs_seen = 0;
  int  fd_seen = 0;
  int  exp_fs = 0;
  bit  synced = 0;
  bit  new_frame = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // href high for len cycles, then one low cycle so the fall is sampled
  task automatic send_line(input int len);
    if (synced && new_frame) begin
      exp_fs++;
      new_frame = 0;
    end
    in_href = 1'b1;
    tick(len);
    in_href = 1'b0;
    tick(1);
  endtask

  task automatic run_lines(input int n, input int len);
    for (int i = 0; i < n; i++) begin
      send_line(len);
      tick(1);
    end
  endtask

  task automatic push_fd(input int lines, input logic errh);
    fd_t e;
    e.lines = lines;
    e.errh  = errh;
    exp_q.push_back(e);
  endtask

  task automatic vsync_pulse(input int lines, input logic errh);
    if (synced) push_fd(lines, errh);
    in_vsync = 1'b1;
    tick(3);
    in_vsync = 1'b0;
    tick(2);
    synced    = 1;
    new_frame = 1;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  // scoreboard side: every frame_done pops the expectation pushed when vsync was driven
  always @(negedge pclk) begin
    if (!rst && frame_start) fs_seen++;
    if (!rst && frame_done) begin
      fd_seen++;
      if (exp_q.size() == 0) begin
        chk("frame_done_unexpected", 32'd1, 32'd0);
      end else begin
        fd_t e;
        e = exp_q.pop_front();
        chk("fd_line_cnt", 32'(line_cnt), 32'(e.lines));
        chk("fd_err_height", 32'(err_height), 32'(e.errh));
      end
    end
  end

  initial begin
    rst = 1'b1; in_vsync = 1'b0; in_href = 1'b0;
    cfg_bayer = 2'd0; cfg_enable = 1'b1; cfg_update = 1'b0; err_clr = 1'b0;
    tick(3);
    chk("rst_act_bayer", 32'(act_bayer), 32'(BAYER));
    chk("rst_act_enable", 32'(act_enable), 32'd1);
    chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);
    chk("rst_line_cnt", 32'(line_cnt), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err_width", 32'(err_width), 32'd0);
    chk("rst_err_height", 32'(err_height), 32'd0);
    rst = 1'b0;
    tick(2);

    // idle: href ignored, cfg applied straight away
    send_line(WIDTH);
    chk("idle_pix_cnt", 32'(pix_cnt), 32'd0);
    chk("idle_line_cnt", 32'(line_cnt), 32'd0);
    cfg_bayer = 2'd2; cfg_enable = 1'b0; cfg_update = 1'b1;
    tick(1);
    cfg_update = 1'b0;
    chk("idle_cfg_bayer", 32'(act_bayer), 32'd2);
    chk("idle_cfg_enable", 32'(act_enable), 32'd0);
    cfg_bayer = 2'd0; cfg_enable = 1'b1; cfg_update = 1'b1;
    tick(1);
    cfg_update = 1'b0;
    chk("idle_cfg_restore", 32'(act_bayer), 32'd0);

    // T1 nominal: three frames, the first vsync comes from idle
    for (int f = 0; f < 3; f++) begin
      if (f == 0) vsync_pulse(0, 1'b0);
      else vsync_pulse(HEIGHT, 1'b0);
      run_lines(HEIGHT, WIDTH);
      chk("t1_line_cnt", 32'(line_cnt), 32'(HEIGHT));
      chk("t1_pix_cnt", 32'(pix_cnt), 32'(WIDTH));
    end
    chk("t1_frame_starts", 32'(fs_seen), 32'd3);
    chk("t1_frame_dones", 32'(fd_seen), 32'd2);
    chk("t1_err_width", 32'(err_width), 32'd0);
    chk("t1_err_height", 32'(err_height), 32'd0);
    chk("t1_act_bayer", 32'(act_bayer), 32'(BAYER));
    vsync_pulse(HEIGHT, 1'b0);

    // T2 shadow: two updates mid-frame, the last one wins at frame_done
    run_lines(2, WIDTH);
    cfg_bayer = 2'd1; cfg_update = 1'b1;
    tick(1);
    cfg_update = 1'b0;
    run_lines(1, WIDTH);
    cfg_bayer = 2'd3; cfg_update = 1'b1;
    tick(1);
    cfg_update = 1'b0;
    chk("t2_hold_mid_frame", 32'(act_bayer), 32'd0);
    run_lines(HEIGHT - 3, WIDTH);
    chk("t2_hold_frame_end", 32'(act_bayer), 32'd0);
    push_fd(HEIGHT, 1'b0);
    in_vsync = 1'b1;
    tick(1);
    chk("t2_frame_done", 32'(frame_done), 32'd1);
    chk("t2_applied_bayer", 32'(act_bayer), 32'd3);
    chk("t2_applied_enable", 32'(act_enable), 32'd1);
    tick(2);
    in_vsync = 1'b0;
    tick(2);
    new_frame = 1;

    // T3 short line
    run_lines(2, WIDTH);
    send_line(WIDTH - 1);
    chk("t3_err_width", 32'(err_width), 32'd1);
    chk("t3_pix_cnt", 32'(pix_cnt), 32'(WIDTH - 1));
    chk("t3_err_height", 32'(err_height), 32'd0);
    tick(1);
    run_lines(HEIGHT - 3, WIDTH);
    vsync_pulse(HEIGHT, 1'b0);
    chk("t3_err_width_sticky", 32'(err_width), 32'd1);
    clear_errors();
    chk("t3_err_width_clr", 32'(err_width), 32'd0);

    // T4 short frame, then err_clr colliding with a new height error
    run_lines(HEIGHT - 1, WIDTH);
    vsync_pulse(HEIGHT - 1, 1'b1);
    chk("t4_err_height", 32'(err_height), 32'd1);
    clear_errors();
    chk("t4_err_height_clr", 32'(err_height), 32'd0);
    run_lines(HEIGHT - 1, WIDTH);
    push_fd(HEIGHT - 1, 1'b1);
    in_vsync = 1'b1; err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t4_clr_vs_new_err", 32'(err_height), 32'd1);
    tick(2);
    in_vsync = 1'b0;
    tick(2);
    new_frame = 1;
    clear_errors();

    // T5 truncation: vsync rises mid-line
    run_lines(2, WIDTH);
    in_href = 1'b1;
    tick(9);
    push_fd(3, 1'b1);
    in_vsync = 1'b1;
    tick(1);
    chk("t5_frame_done", 32'(frame_done), 32'd1);
    chk("t5_line_cnt", 32'(line_cnt), 32'd3);
    chk("t5_err_width", 32'(err_width), 32'd1);
    in_href = 1'b0;
    tick(2);
    in_vsync = 1'b0;
    tick(2);
    chk("t5_line_cnt_cleared", 32'(line_cnt), 32'd0);
    new_frame = 1;
    clear_errors();

    // pixel counter saturation on an over-long line
    run_lines(2, WIDTH);
    send_line(70);
    chk("sat_pix_cnt", 32'(pix_cnt), 32'((1 << CNT_W) - 1));
    chk("sat_err_width", 32'(err_width), 32'd1);
    tick(1);
    run_lines(HEIGHT - 3, WIDTH);
    vsync_pulse(HEIGHT, 1'b0);
    clear_errors();

    // T6 reset mid-line with an error flag set and a config pending
    run_lines(1, WIDTH);
    send_line(WIDTH - 2);
    tick(1);
    cfg_bayer = 2'd1; cfg_update = 1'b1;
    tick(1);
    cfg_update = 1'b0; cfg_bayer = 2'd0;
    in_href = 1'b1;
    tick(5);
    rst = 1'b1; synced = 0; new_frame = 0;
    tick(1);
    rst = 1'b0;
    chk("t6_act_bayer", 32'(act_bayer), 32'(BAYER));
    chk("t6_act_enable", 32'(act_enable), 32'd1);
    chk("t6_pix_cnt", 32'(pix_cnt), 32'd0);
    chk("t6_line_cnt", 32'(line_cnt), 32'd0);
    chk("t6_err_width", 32'(err_width), 32'd0);
    chk("t6_err_height", 32'(err_height), 32'd0);
    tick(4);
    in_href = 1'b0;
    tick(3);
    chk("t6_pending_dropped", 32'(act_bayer), 32'(BAYER));
    chk("t6_href_ignored", 32'(pix_cnt), 32'd0);
    send_line(WIDTH);
    tick(1);
    chk("t6_lines_ignored", 32'(line_cnt), 32'd0);
    vsync_pulse(0, 1'b0);
    run_lines(HEIGHT, WIDTH);
    vsync_pulse(HEIGHT, 1'b0);
    tick(3);

    chk("end_frame_done_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("end_frame_start_count", 32'(fs_seen), 32'(exp_fs));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
